// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI burst slave and its address generator.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // log2 of the number of byte lanes on a data bus of the given width
    function automatic int lanes_log2(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address and per-beat legality for one AXI channel.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 3,
    parameter int LEN_W     = 4,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [SIZE-1:0]   size_i,
    input  logic [SIZE-2:0]   burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              burst_err_o,
    output logic              range_err_o
);

    localparam int LB = lanes_log2(WIDTH);

    logic [ADDR_W:0]   step_s;
    logic [ADDR_W:0]   bound_s;
    logic [ADDR_W:0]   end_s;
    logic [LEN_W:0]    beats_s;
    logic [ADDR_W-1:0] inc_s;
    logic [ADDR_W-1:0] mask_s;
    logic              wrap_ok_s;
    logic              kind_bad_s;

    // Next address by burst type, plus size/length/range legality of this beat
    always_comb begin
        step_s      = (ADDR_W+1)'(1) << size_i;
        beats_s     = {1'b0, len_i} + (LEN_W+1)'(1);
        bound_s     = (ADDR_W+1)'(beats_s) << size_i;
        mask_s      = bound_s[ADDR_W-1:0] - ADDR_W'(1);
        inc_s       = addr_i + step_s[ADDR_W-1:0];
        end_s       = {1'b0, addr_i} + step_s;
        range_err_o = (end_s > (ADDR_W+1)'(MEM_BYTES));
        wrap_ok_s   = (beats_s == (LEN_W+1)'(2)) || (beats_s == (LEN_W+1)'(4)) ||
                      (beats_s == (LEN_W+1)'(8)) || (beats_s == (LEN_W+1)'(16));
        case (burst_t'(burst_i))
            FIXED: begin
                next_addr_o = addr_i;
                kind_bad_s  = 1'b0;
            end
            INCR: begin
                next_addr_o = inc_s;
                kind_bad_s  = 1'b0;
            end
            WRAP: begin
                next_addr_o = (addr_i & ~mask_s) | (inc_s & mask_s);
                kind_bad_s  = !wrap_ok_s;
            end
            default: begin
                // reserved burst encoding is treated like an illegal burst
                next_addr_o = addr_i;
                kind_bad_s  = 1'b1;
            end
        endcase
        burst_err_o = (size_i > SIZE'(LB)) || kind_bad_s;
    end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI3-style byte-addressed memory slave with independent write and read engines.
module axi_burst_slave
    import axi_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 3,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ID_W-1:0]      awid,
    input  logic [ADDR_W-1:0]    awaddr,
    input  logic [LEN_W-1:0]     awlen,
    input  logic [SIZE-1:0]      awsize,
    input  logic [SIZE-2:0]      awburst,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ID_W-1:0]      wid,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [ID_W-1:0]      bid,
    output logic [SIZE-2:0]      bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [ID_W-1:0]      arid,
    input  logic [ADDR_W-1:0]    araddr,
    input  logic [LEN_W-1:0]     arlen,
    input  logic [SIZE-1:0]      arsize,
    input  logic [SIZE-2:0]      arburst,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [ID_W-1:0]      rid,
    output logic [WIDTH-1:0]     rdata,
    output logic [SIZE-2:0]      rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready
);

    localparam int NB  = WIDTH / 8;
    localparam int MAW = $clog2(MEM_BYTES);

    logic [7:0] mem [MEM_BYTES];

    // write channel state
    w_state_t           w_state_q;
    logic [ID_W-1:0]    wid_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [LEN_W-1:0]   wlen_q, wbeat_q;
    logic [SIZE-1:0]    wsize_q;
    logic [SIZE-2:0]    wburst_q;
    logic               werr_q, werr_d;
    logic               awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]    bid_q;
    logic [SIZE-2:0]    bresp_q;
    logic [ADDR_W-1:0]  wnext_s;
    logic               wburst_err_s, wrange_err_s, wfire_s;
    logic [ADDR_W:0]    wstep_s, wszbase_s, wlo_s, whi_s, wbase_s;
    logic [NB-1:0]      wlane_s;

    // read channel state
    r_state_t           r_state_q;
    logic [ID_W-1:0]    rid_q;
    logic [ADDR_W-1:0]  rnext_q;
    logic [LEN_W-1:0]   rlen_q, rbeat_q;
    logic [SIZE-1:0]    rsize_q;
    logic [SIZE-2:0]    rburst_q;
    logic               arready_q, rvalid_q, rlast_q;
    logic [WIDTH-1:0]   rdata_q;
    logic [SIZE-2:0]    rresp_q;
    logic [ADDR_W-1:0]  rg_addr_s, rg_next_s, rbase_s;
    logic [LEN_W-1:0]   rg_len_s;
    logic [SIZE-1:0]    rg_size_s;
    logic [SIZE-2:0]    rg_burst_s;
    logic               rburst_err_s, rrange_err_s, rbad_s, rload_last_s;
    logic [WIDTH-1:0]   rword_s;

    axi_addr_gen #(
        .WIDTH(WIDTH), .SIZE(SIZE), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)
    ) u_wgen (
        .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
        .next_addr_o(wnext_s), .burst_err_o(wburst_err_s), .range_err_o(wrange_err_s)
    );

    // the read generator looks at the AR inputs while idle so beat 0 can load at the handshake
    axi_addr_gen #(
        .WIDTH(WIDTH), .SIZE(SIZE), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)
    ) u_rgen (
        .addr_i(rg_addr_s), .len_i(rg_len_s), .size_i(rg_size_s), .burst_i(rg_burst_s),
        .next_addr_o(rg_next_s), .burst_err_o(rburst_err_s), .range_err_o(rrange_err_s)
    );

    // Byte lanes of the current write beat and the sticky error including this beat
    always_comb begin
        wfire_s   = (w_state_q == W_DATA) && wvalid && wready_q;
        wstep_s   = (ADDR_W+1)'(1) << wsize_q;
        wszbase_s = {1'b0, waddr_q} & ~(wstep_s - (ADDR_W+1)'(1));
        wlo_s     = (wbeat_q == {LEN_W{1'b0}}) ? {1'b0, waddr_q} : wszbase_s;
        whi_s     = wszbase_s + wstep_s;
        wbase_s   = {1'b0, waddr_q} & ~(ADDR_W+1)'(NB - 1);
        for (int i = 0; i < NB; i++) begin
            wlane_s[i] = ((wbase_s + (ADDR_W+1)'(i)) >= wlo_s) &&
                         ((wbase_s + (ADDR_W+1)'(i)) < whi_s);
        end
        werr_d = werr_q || wburst_err_s || wrange_err_s || (wid != wid_q) ||
                 (wlast != (wbeat_q == wlen_q));
    end

    // Commit strobed, in-size byte lanes of legal in-range beats; memory has no reset
    always_ff @(posedge clk) begin
        if (wfire_s && !wburst_err_s && !wrange_err_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wlane_s[i] && wstrb[i]) begin
                    mem[MAW'(wbase_s + (ADDR_W+1)'(i))] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Write FSM: accept AW, take len+1 beats, then hold B until bready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= {ID_W{1'b0}};
            bresp_q   <= {(SIZE-1){1'b0}};
            wid_q     <= {ID_W{1'b0}};
            waddr_q   <= {ADDR_W{1'b0}};
            wlen_q    <= {LEN_W{1'b0}};
            wbeat_q   <= {LEN_W{1'b0}};
            wsize_q   <= {SIZE{1'b0}};
            wburst_q  <= {(SIZE-1){1'b0}};
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid && awready_q) begin
                        wid_q     <= awid;
                        waddr_q   <= awaddr;
                        wlen_q    <= awlen;
                        wsize_q   <= awsize;
                        wburst_q  <= awburst;
                        wbeat_q   <= {LEN_W{1'b0}};
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wfire_s) begin
                        werr_q  <= werr_d;
                        waddr_q <= wnext_s;
                        wbeat_q <= wbeat_q + LEN_W'(1);
                        // burst length follows awlen; wlast only feeds the error flag
                        if (wbeat_q == wlen_q) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= wid_q;
                            bresp_q   <= werr_d ? (SIZE-1)'(SLVERR) : (SIZE-1)'(OKAY);
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bready) begin
                        bvalid_q  <= 1'b0;
                        bid_q     <= {ID_W{1'b0}};
                        bresp_q   <= {(SIZE-1){1'b0}};
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Select the beat the read side will load next and fetch its aligned word
    always_comb begin
        if (r_state_q == R_IDLE) begin
            rg_addr_s    = araddr;
            rg_len_s     = arlen;
            rg_size_s    = arsize;
            rg_burst_s   = arburst;
            rload_last_s = (arlen == {LEN_W{1'b0}});
        end else begin
            rg_addr_s    = rnext_q;
            rg_len_s     = rlen_q;
            rg_size_s    = rsize_q;
            rg_burst_s   = rburst_q;
            rload_last_s = ((rbeat_q + LEN_W'(1)) == rlen_q);
        end
        rbad_s  = rburst_err_s || rrange_err_s;
        rbase_s = rg_addr_s & ~ADDR_W'(NB - 1);
        for (int i = 0; i < NB; i++) begin
            rword_s[8*i +: 8] = mem[MAW'(rbase_s + ADDR_W'(i))];
        end
    end

    // Read FSM: load beat 0 at the AR handshake, then one beat per R handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= {WIDTH{1'b0}};
            rresp_q   <= {(SIZE-1){1'b0}};
            rid_q     <= {ID_W{1'b0}};
            rnext_q   <= {ADDR_W{1'b0}};
            rlen_q    <= {LEN_W{1'b0}};
            rbeat_q   <= {LEN_W{1'b0}};
            rsize_q   <= {SIZE{1'b0}};
            rburst_q  <= {(SIZE-1){1'b0}};
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= arid;
                        rlen_q    <= arlen;
                        rsize_q   <= arsize;
                        rburst_q  <= arburst;
                        rnext_q   <= rg_next_s;
                        rbeat_q   <= {LEN_W{1'b0}};
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rbad_s ? {WIDTH{1'b0}} : rword_s;
                        rresp_q   <= rbad_s ? (SIZE-1)'(SLVERR) : (SIZE-1)'(OKAY);
                        rlast_q   <= rload_last_s;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rdata_q   <= {WIDTH{1'b0}};
                            rresp_q   <= {(SIZE-1){1'b0}};
                            rid_q     <= {ID_W{1'b0}};
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rbeat_q <= rbeat_q + LEN_W'(1);
                            rnext_q <= rg_next_s;
                            rdata_q <= rbad_s ? {WIDTH{1'b0}} : rword_s;
                            rresp_q <= rbad_s ? (SIZE-1)'(SLVERR) : (SIZE-1)'(OKAY);
                            rlast_q <= rload_last_s;
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Self-checking bench for axi_burst_slave against a byte-array reference model.
module tb_axi_burst_slave;

    localparam int WIDTH = 32, SIZE = 3, ID_W = 4, LEN_W = 4, ADDR_W = 32, MEM_BYTES = 4096;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [ID_W-1:0]   awid = '0, wid = '0, arid = '0;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [LEN_W-1:0]  awlen = '0, arlen = '0;
    logic [SIZE-1:0]   awsize = '0, arsize = '0;
    logic [SIZE-2:0]   awburst = '0, arburst = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic              arvalid = 1'b0, rready = 1'b0;
    logic [WIDTH-1:0]  wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              awready, wready, bvalid, arready, rvalid, rlast;
    logic [ID_W-1:0]   bid, rid;
    logic [SIZE-2:0]   bresp, rresp;
    logic [WIDTH-1:0]  rdata;

    axi_burst_slave #(.WIDTH(WIDTH), .SIZE(SIZE), .ID_W(ID_W), .LEN_W(LEN_W),
                      .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem_m [MEM_BYTES];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_cap [16];
    logic [1:0]  last_bresp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int len, input int size, input int burst);
        int beats = len + 1;
        if (size > 2 || burst > 2) return 1'b0;
        if (burst == 2 && !(beats == 2 || beats == 4 || beats == 8 || beats == 16)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit in_range(input logic [31:0] a, input int size);
        return (longint'(a) + (longint'(1) << size)) <= MEM_BYTES;
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a, input int len, input int size, input int burst);
        logic [31:0] step  = 32'd1 << size;
        logic [31:0] bound = (len + 1) * step;
        if (burst == 0) return a;
        if (burst == 1) return a + step;
        return (a & ~(bound - 32'd1)) | ((a + step) & (bound - 32'd1));
    endfunction

    function automatic logic [31:0] word_m(input logic [31:0] a);
        logic [31:0] b = a & ~32'd3;
        return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
    endfunction

    task automatic wr(input int id, input logic [31:0] addr, input int len, input int size,
                      input int burst, input int bad_id_beat, input bit bad_last,
                      input int bstall, input int rst_beat);
        logic [31:0] a, sz, lo, hi, b;
        bit err, ok;
        int to;
        a = addr; ok = legal(len, size, burst); err = !ok;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        to = 0;
        while (!awready && to < 50) begin @(negedge clk); to++; end
        chk("aw_wait", to < 50, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            if (n == rst_beat) begin
                wid = id; wdata = wd[n]; wstrb = ws[n]; wlast = (n == len); wvalid = 1'b1;
                resetn = 1'b0;
                #1;
                chk("rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
                chk("rst_ids", {bid, bresp, rid, rresp}, 0);
                chk("rst_rdata", rdata, 0);
                wvalid = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                return;
            end
            wid = (n == bad_id_beat) ? id ^ 1 : id;
            wdata = wd[n]; wstrb = ws[n];
            wlast = bad_last ? (n != len) : (n == len);
            wvalid = 1'b1;
            to = 0;
            while (!wready && to < 50) begin @(negedge clk); to++; end
            chk("w_wait", to < 50, 1);
            @(negedge clk);
            wvalid = 1'b0;
            if (wid != id || wlast != (n == len) || !in_range(a, size)) err = 1'b1;
            if (ok && in_range(a, size)) begin
                sz = 32'd1 << size;
                lo = (n == 0) ? a : (a & ~(sz - 1));
                hi = (a & ~(sz - 1)) + sz;
                for (int i = 0; i < 4; i++) begin
                    b = (a & ~32'd3) + i;
                    if (b >= lo && b < hi && ws[n][i]) mem_m[b] = wd[n][8*i +: 8];
                end
            end
            a = nxt(a, len, size, burst);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        to = 0;
        while (!bvalid && to < 50) begin @(negedge clk); to++; end
        chk("b_wait", to < 50, 1);
        chk("b_wready", wready, 0);
        last_bresp = bresp;
        for (int k = 0; k <= bstall; k++) begin
            chk("b_valid", bvalid, 1);
            chk("b_id", bid, id);
            chk("b_resp", bresp, err ? 2 : 0);
            chk("b_awready", awready, 0);
            if (k < bstall) @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", bvalid, 0);
        chk("b_aw_back", awready, 1);
    endtask

    task automatic rd(input int id, input logic [31:0] addr, input int len, input int size, input int burst);
        logic [31:0] a;
        logic [31:0] exp_d [16];
        logic [1:0]  exp_r [16];
        int n, guard, to;
        a = addr;
        for (int k = 0; k <= len; k++) begin
            if (legal(len, size, burst) && in_range(a, size)) begin
                exp_d[k] = word_m(a); exp_r[k] = 2'd0;
            end else begin
                exp_d[k] = 32'd0; exp_r[k] = 2'd2;
            end
            a = nxt(a, len, size, burst);
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        to = 0;
        while (!arready && to < 50) begin @(negedge clk); to++; end
        chk("ar_wait", to < 50, 1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_latency", rvalid, 1);
        n = 0; guard = 0;
        while (n <= len && guard < 300) begin
            chk("r_valid", rvalid, 1);
            chk("r_data", rdata, exp_d[n]);
            chk("r_resp", rresp, exp_r[n]);
            chk("r_last", rlast, n == len);
            chk("r_id", rid, id);
            rd_cap[n] = rdata;
            rready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rready) n++;
            guard++;
        end
        rready = 1'b0;
        chk("r_beats", n, len + 1);
        chk("r_done", rvalid, 0);
        chk("r_ar_back", arready, 1);
    endtask

    initial begin
        int id, len, size, burst;
        logic [31:0] addr;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
        chk("reset_ids", {bid, bresp, rid, rresp}, 0);
        chk("reset_rdata", rdata, 0);
        resetn = 1'b1;
        chk("ready_before_edge", {awready, arready}, 0);
        @(negedge clk);
        chk("ready_after_edge", {awready, arready}, 2'b11);

        // known contents everywhere before anything is read
        for (int blk = 0; blk < MEM_BYTES / 64; blk++) begin
            for (int n = 0; n < 16; n++) begin
                wd[n] = $urandom; ws[n] = 4'hF;
            end
            wr(blk & 15, blk * 64, 15, 2, 1, -1, 1'b0, 0, -1);
        end

        for (int n = 0; n < 4; n++) begin wd[n] = 32'hA0 + n; ws[n] = 4'hF; end
        wr(5, 32'h10, 3, 2, 1, -1, 1'b0, 0, -1);
        chk("incr_bresp", last_bresp, 0);
        rd(5, 32'h10, 3, 2, 1);
        for (int n = 0; n < 4; n++) chk("incr_readback", rd_cap[n], 32'hA0 + n);

        for (int n = 0; n < 4; n++) wd[n] = 32'hB0 + n;
        wr(6, 32'h38, 3, 2, 2, -1, 1'b0, 0, -1);
        rd(6, 32'h30, 3, 2, 1);
        chk("wrap_0x30", rd_cap[0], 32'hB2);
        chk("wrap_0x34", rd_cap[1], 32'hB3);
        chk("wrap_0x38", rd_cap[2], 32'hB0);
        chk("wrap_0x3c", rd_cap[3], 32'hB1);

        wd[0] = 32'h0000_5500; ws[0] = 4'h2;
        wr(1, 32'h41, 0, 0, 1, -1, 1'b0, 0, -1);
        rd(1, 32'h40, 0, 2, 1);
        chk("narrow_byte", rd_cap[0][15:8], 8'h55);

        ws[0] = 4'hF; ws[1] = 4'hF; wd[0] = 32'hC0DE_0001; wd[1] = 32'hC0DE_0002;
        wr(2, MEM_BYTES - 4, 1, 2, 1, -1, 1'b0, 0, -1);
        chk("oob_bresp", last_bresp, 2);
        rd(2, MEM_BYTES - 4, 0, 2, 1);
        chk("oob_beat0", rd_cap[0], 32'hC0DE_0001);

        rd(3, 32'h100, 2, 2, 2);
        chk("wrap3_data", rd_cap[0], 0);

        for (int n = 0; n < 4; n++) wd[n] = 32'hD0 + n;
        wr(7, 32'h200, 3, 2, 1, -1, 1'b0, 5, -1);
        wr(8, 32'h210, 3, 2, 1, 2, 1'b0, 0, -1);
        chk("bad_wid_bresp", last_bresp, 2);
        wr(9, 32'h220, 3, 2, 1, -1, 1'b1, 0, -1);
        chk("bad_wlast_bresp", last_bresp, 2);

        for (int n = 0; n < 4; n++) wd[n] = 32'hE0 + n;
        wr(4, 32'h300, 3, 2, 1, -1, 1'b0, 0, 2);
        chk("post_rst_aw_low", awready, 0);
        @(negedge clk);
        chk("post_rst_aw_high", awready, 1);
        for (int n = 0; n < 4; n++) wd[n] = 32'hF0 + n;
        wr(4, 32'h310, 3, 2, 1, -1, 1'b0, 0, -1);
        chk("post_rst_bresp", last_bresp, 0);
        rd(4, 32'h300, 3, 2, 1);
        chk("partial_beat0", rd_cap[0], 32'hE0);
        chk("partial_beat1", rd_cap[1], 32'hE1);

        for (int t = 0; t < 60; t++) begin
            id = $urandom_range(0, 15);
            len = $urandom_range(0, 15);
            size = $urandom_range(0, 3);
            burst = $urandom_range(0, 2);
            addr = ($urandom_range(0, 7) == 0) ? MEM_BYTES - $urandom_range(1, 40)
                                                : $urandom_range(0, MEM_BYTES - 1);
            for (int n = 0; n < 16; n++) begin wd[n] = $urandom; ws[n] = $urandom; end
            wr(id, addr, len, size, burst, ($urandom_range(0, 9) == 0) ? 0 : -1,
               ($urandom_range(0, 9) == 0), $urandom_range(0, 2), -1);
            rd(id, addr, len, size, burst);
            rd($urandom_range(0, 15), addr & ~32'd3, $urandom_range(0, 15), 2, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
